// File: rtl/id_stage_pkg.sv
// -----------------------------------------------------------------------------
// id_stage_pkg
// Shared definitions for the decode stage of the RV32I-subset core:
//   - opcode, funct3 and funct7 constants for the supported encodings
//   - NOP_INSTR, the bubble (addi x0,x0,0) loaded into IF/ID on reset/flush
//   - ctrl_t, the packed set of ten one-hot operation controls
//   - decode_instr(), the combinational instruction decoder
// -----------------------------------------------------------------------------
package id_stage_pkg;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Opcodes
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   // funct3 values
   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLL     = 3'b001;
   localparam logic [2:0] F3_SRA     = 3'b101;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [2:0] F3_ADDI    = 3'b000;
   localparam logic [2:0] F3_WORD    = 3'b010;
   localparam logic [2:0] F3_BEQ     = 3'b000;

   // funct7 values
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef struct packed {
      logic add_op;
      logic sub_op;
      logic and_op;
      logic or_op;
      logic addi_op;
      logic sll_op;
      logic sra_op;
      logic beq_op;
      logic sw_op;
      logic lw_op;
   } ctrl_t;

   // Returns at most one control bit set; all-zero means the encoding is not
   // supported. funct7 is only inspected for R-type instructions.
   function automatic ctrl_t decode_instr(input logic [31:0] instr);
      ctrl_t      c;
      logic [6:0] opcode;
      logic [2:0] funct3;
      logic [6:0] funct7;
      opcode = instr[6:0];
      funct3 = instr[14:12];
      funct7 = instr[31:25];
      // NOTE: every decoded bit gets a default before the case so that no path
      // leaves a value unassigned; in an always_comb that would infer a latch.
      c = '0;
      case (opcode)
         OP_RTYPE: begin
            case ({funct7, funct3})
               {F7_BASE, F3_ADD_SUB}: c.add_op = 1'b1;
               {F7_ALT,  F3_ADD_SUB}: c.sub_op = 1'b1;
               {F7_BASE, F3_SLL}:     c.sll_op = 1'b1;
               {F7_ALT,  F3_SRA}:     c.sra_op = 1'b1;
               {F7_BASE, F3_AND}:     c.and_op = 1'b1;
               {F7_BASE, F3_OR}:      c.or_op  = 1'b1;
               default:               c = '0;
            endcase
         end
         OP_IMM:    if (funct3 == F3_ADDI) c.addi_op = 1'b1;
         OP_LOAD:   if (funct3 == F3_WORD) c.lw_op   = 1'b1;
         OP_STORE:  if (funct3 == F3_WORD) c.sw_op   = 1'b1;
         OP_BRANCH: if (funct3 == F3_BEQ)  c.beq_op  = 1'b1;
         default:   c = '0;
      endcase
      return c;
   endfunction

endpackage : id_stage_pkg

// File: rtl/id_ex_reg32.sv
// -----------------------------------------------------------------------------
// id_ex_reg32
// Pipeline register for one ID/EX data path. Loads i_d every cycle (no
// enable); synchronous active-high reset clears it to zero.
// Ports:
//   i_clk   rising-edge clock
//   i_rst   synchronous active-high reset
//   i_d     data captured each edge
//   o_q     registered data (1-cycle latency)
// -----------------------------------------------------------------------------
module id_ex_reg32 #(
   parameter int WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_q;

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples its inputs as they were before the clock edge.
   always_ff @(posedge i_clk) begin
      if (i_rst) r_q <= '0;
      else       r_q <= i_d;
   end

   assign o_q = r_q;

endmodule : id_ex_reg32

// File: rtl/id_stage_controller.sv
// -----------------------------------------------------------------------------
// id_stage_controller
// Decode stage of the 5-stage RV32I-subset core. Holds the IF/ID instruction
// latch, decodes it into one-hot operation controls and registers operand A,
// operand B and the immediate into the ID/EX latches.
//
// Build option: define ID_EX_CTRL_EN to register the ten controls and
// illegal_instr in ID/EX (1-cycle latency, reset to 0). Without it they are
// combinational from full_instruction.
//
// Ports:
//   clock, reset           rising-edge clock, synchronous active-high reset
//   instruction_reg_out    fetched instruction
//   if_id_stall            hold IF/ID
//   if_id_flush            load NOP into IF/ID (wins over stall)
//   full_instruction       IF/ID instruction
//   A_data, B_data         register-bank rs1/rs2 data
//   imm_data               sign-extended immediate
//   A_ID_EX_data, B_ID_EX_data, ID_EX_immediate_data   ID/EX registered data
//   *_control              one-hot operation controls
//   illegal_instr          no supported encoding matched
// -----------------------------------------------------------------------------
module id_stage_controller
   import id_stage_pkg::*;
#(
   parameter int                    DATA_WIDTH = 32,
   parameter logic [DATA_WIDTH-1:0] NOP_INSTR  = id_stage_pkg::NOP_INSTR
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic [DATA_WIDTH-1:0] instruction_reg_out,
   input  logic                  if_id_stall,
   input  logic                  if_id_flush,
   output logic [DATA_WIDTH-1:0] full_instruction,
   input  logic [DATA_WIDTH-1:0] A_data,
   input  logic [DATA_WIDTH-1:0] B_data,
   input  logic [DATA_WIDTH-1:0] imm_data,
   output logic [DATA_WIDTH-1:0] A_ID_EX_data,
   output logic [DATA_WIDTH-1:0] B_ID_EX_data,
   output logic [DATA_WIDTH-1:0] ID_EX_immediate_data,
   output logic                  add_control,
   output logic                  sub_control,
   output logic                  and_control,
   output logic                  or_control,
   output logic                  addi_control,
   output logic                  sll_control,
   output logic                  sra_control,
   output logic                  beq_control,
   output logic                  sw_control,
   output logic                  lw_control,
   output logic                  illegal_instr
);

   // ---------------------------------------------------------------- IF/ID
   logic [DATA_WIDTH-1:0] r_if_id;

   // Priority: reset > flush > stall > capture.
   always_ff @(posedge clock) begin
      if (reset)            r_if_id <= NOP_INSTR;
      else if (if_id_flush) r_if_id <= NOP_INSTR;
      else if (!if_id_stall) r_if_id <= instruction_reg_out;
   end

   assign full_instruction = r_if_id;

   // ---------------------------------------------------------------- decode
   ctrl_t w_ctrl;
   logic  w_illegal;

   assign w_ctrl    = decode_instr(r_if_id);
   assign w_illegal = (w_ctrl == '0);

   ctrl_t w_ctrl_out;
   logic  w_illegal_out;

`ifdef ID_EX_CTRL_EN
   ctrl_t r_ctrl;
   logic  r_illegal;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_ctrl    <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_ctrl    <= w_ctrl;
         r_illegal <= w_illegal;
      end
   end

   assign w_ctrl_out    = r_ctrl;
   assign w_illegal_out = r_illegal;
`else
   assign w_ctrl_out    = w_ctrl;
   assign w_illegal_out = w_illegal;
`endif

   assign add_control   = w_ctrl_out.add_op;
   assign sub_control   = w_ctrl_out.sub_op;
   assign and_control   = w_ctrl_out.and_op;
   assign or_control    = w_ctrl_out.or_op;
   assign addi_control  = w_ctrl_out.addi_op;
   assign sll_control   = w_ctrl_out.sll_op;
   assign sra_control   = w_ctrl_out.sra_op;
   assign beq_control   = w_ctrl_out.beq_op;
   assign sw_control    = w_ctrl_out.sw_op;
   assign lw_control    = w_ctrl_out.lw_op;
   assign illegal_instr = w_illegal_out;

   // ---------------------------------------------------------------- ID/EX data
   id_ex_reg32 #(.WIDTH(DATA_WIDTH)) u_a_reg (
      .i_clk (clock),
      .i_rst (reset),
      .i_d   (A_data),
      .o_q   (A_ID_EX_data)
   );

   id_ex_reg32 #(.WIDTH(DATA_WIDTH)) u_b_reg (
      .i_clk (clock),
      .i_rst (reset),
      .i_d   (B_data),
      .o_q   (B_ID_EX_data)
   );

   id_ex_reg32 #(.WIDTH(DATA_WIDTH)) u_imm_reg (
      .i_clk (clock),
      .i_rst (reset),
      .i_d   (imm_data),
      .o_q   (ID_EX_immediate_data)
   );

endmodule : id_stage_controller

// File: tb/tb_id_stage_controller.sv
// -----------------------------------------------------------------------------
// tb_id_stage_controller
// Directed-vector bench for id_stage_controller (default build, combinational
// controls). Inputs change 1 time unit after the rising edge; outputs are
// checked at that same point, well away from the next edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_id_stage_controller;

   // Control vector layout: {illegal, lw, sw, beq, sra, sll, addi, or, and, sub, add}
   localparam logic [10:0] C_ADD  = 11'b000_0000_0001;
   localparam logic [10:0] C_SUB  = 11'b000_0000_0010;
   localparam logic [10:0] C_AND  = 11'b000_0000_0100;
   localparam logic [10:0] C_OR   = 11'b000_0000_1000;
   localparam logic [10:0] C_ADDI = 11'b000_0001_0000;
   localparam logic [10:0] C_SLL  = 11'b000_0010_0000;
   localparam logic [10:0] C_SRA  = 11'b000_0100_0000;
   localparam logic [10:0] C_BEQ  = 11'b000_1000_0000;
   localparam logic [10:0] C_SW   = 11'b001_0000_0000;
   localparam logic [10:0] C_LW   = 11'b010_0000_0000;
   localparam logic [10:0] C_ILL  = 11'b100_0000_0000;

   logic        clock;
   logic        reset;
   logic [31:0] instruction_reg_out;
   logic        if_id_stall;
   logic        if_id_flush;
   logic [31:0] full_instruction;
   logic [31:0] A_data, B_data, imm_data;
   logic [31:0] A_ID_EX_data, B_ID_EX_data, ID_EX_immediate_data;
   logic        add_control, sub_control, and_control, or_control;
   logic        addi_control, sll_control, sra_control;
   logic        beq_control, sw_control, lw_control;
   logic        illegal_instr;

   int n_vec  = 0;
   int n_miss = 0;

   id_stage_controller dut (
      .clock                (clock),
      .reset                (reset),
      .instruction_reg_out  (instruction_reg_out),
      .if_id_stall          (if_id_stall),
      .if_id_flush          (if_id_flush),
      .full_instruction     (full_instruction),
      .A_data               (A_data),
      .B_data               (B_data),
      .imm_data             (imm_data),
      .A_ID_EX_data         (A_ID_EX_data),
      .B_ID_EX_data         (B_ID_EX_data),
      .ID_EX_immediate_data (ID_EX_immediate_data),
      .add_control          (add_control),
      .sub_control          (sub_control),
      .and_control          (and_control),
      .or_control           (or_control),
      .addi_control         (addi_control),
      .sll_control          (sll_control),
      .sra_control          (sra_control),
      .beq_control          (beq_control),
      .sw_control           (sw_control),
      .lw_control           (lw_control),
      .illegal_instr        (illegal_instr)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [10:0] ctrl_vec();
      return {illegal_instr, lw_control, sw_control, beq_control, sra_control,
              sll_control, addi_control, or_control, and_control, sub_control,
              add_control};
   endfunction

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      n_vec++;
      if (observed !== expected) begin
         n_miss++;
         $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Advance to 1 time unit past the next rising edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   typedef struct {
      logic [31:0] instr;
      logic [10:0] ctrl;
      string       name;
   } vec_t;

   vec_t sweep[12];

   initial begin
      sweep[0]  = '{32'h0050_0093, C_ADDI, "addi"};
      sweep[1]  = '{32'h0080_A283, C_LW,   "lw"};
      sweep[2]  = '{32'h0050_A623, C_SW,   "sw"};
      sweep[3]  = '{32'h0020_8463, C_BEQ,  "beq"};
      sweep[4]  = '{32'h4020_D1B3, C_SRA,  "sra"};
      sweep[5]  = '{32'h0020_91B3, C_SLL,  "sll"};
      sweep[6]  = '{32'h0020_F1B3, C_AND,  "and"};
      sweep[7]  = '{32'h0020_E1B3, C_OR,   "or"};
      sweep[8]  = '{32'h0020_C1B3, C_ILL,  "xor_unsupported"};
      sweep[9]  = '{32'h2020_81B3, C_ILL,  "rtype_bad_funct7"};
      sweep[10] = '{32'hFFF0_0093, C_ADDI, "addi_neg_imm"};
      sweep[11] = '{32'h0000_0000, C_ILL,  "all_zero"};

      reset               = 1'b1;
      instruction_reg_out = 32'h0020_81B3;
      if_id_stall         = 1'b0;
      if_id_flush         = 1'b0;
      A_data              = 32'h1111_1111;
      B_data              = 32'h2222_2222;
      imm_data            = 32'h3333_3333;

      // Reset held for two edges
      step();
      step();
      check("rst_if_id",  full_instruction, 32'h0000_0013);
      check("rst_ctrl",   {21'd0, ctrl_vec()}, {21'd0, C_ADDI});
      check("rst_a",      A_ID_EX_data, 32'h0);
      check("rst_b",      B_ID_EX_data, 32'h0);
      check("rst_imm",    ID_EX_immediate_data, 32'h0);

      // add then sub, each visible one edge after being driven
      reset = 1'b0;
      instruction_reg_out = 32'h0020_81B3;
      step();
      check("add_if_id", full_instruction, 32'h0020_81B3);
      check("add_ctrl",  {21'd0, ctrl_vec()}, {21'd0, C_ADD});
      instruction_reg_out = 32'h4020_81B3;
      check("add_before_sub_edge", {21'd0, ctrl_vec()}, {21'd0, C_ADD});
      step();
      check("sub_if_id", full_instruction, 32'h4020_81B3);
      check("sub_ctrl",  {21'd0, ctrl_vec()}, {21'd0, C_SUB});

      // Decoder sweep
      for (int i = 0; i < 12; i++) begin
         instruction_reg_out = sweep[i].instr;
         step();
         check({sweep[i].name, "_if_id"}, full_instruction, sweep[i].instr);
         check({sweep[i].name, "_ctrl"}, {21'd0, ctrl_vec()}, {21'd0, sweep[i].ctrl});
      end

      // Stall holds IF/ID while the input moves
      instruction_reg_out = 32'h0020_81B3;
      step();
      if_id_stall = 1'b1;
      instruction_reg_out = 32'h4020_D1B3;
      step();
      check("stall_hold1", full_instruction, 32'h0020_81B3);
      check("stall_ctrl",  {21'd0, ctrl_vec()}, {21'd0, C_ADD});
      instruction_reg_out = 32'h0080_A283;
      step();
      check("stall_hold2", full_instruction, 32'h0020_81B3);

      // Stall and flush together: flush wins
      if_id_flush = 1'b1;
      step();
      check("flush_stall_if_id", full_instruction, 32'h0000_0013);
      check("flush_stall_ctrl",  {21'd0, ctrl_vec()}, {21'd0, C_ADDI});

      // Flush alone
      if_id_stall = 1'b0;
      instruction_reg_out = 32'h0050_A623;
      step();
      check("flush_only_if_id", full_instruction, 32'h0000_0013);
      if_id_flush = 1'b0;
      step();
      check("post_flush_if_id", full_instruction, 32'h0050_A623);

      // ID/EX data latches, 1-cycle latency
      A_data   = 32'hDEAD_BEEF;
      B_data   = 32'h1234_5678;
      imm_data = 32'hFFFF_FFF8;
      step();
      check("idex_a",   A_ID_EX_data, 32'hDEAD_BEEF);
      check("idex_b",   B_ID_EX_data, 32'h1234_5678);
      check("idex_imm", ID_EX_immediate_data, 32'hFFFF_FFF8);
      A_data   = 32'h0000_0001;
      B_data   = 32'h8000_0000;
      imm_data = 32'h0000_07FF;
      check("idex_a_hold_before_edge", A_ID_EX_data, 32'hDEAD_BEEF);
      step();
      check("idex_a2",   A_ID_EX_data, 32'h0000_0001);
      check("idex_b2",   B_ID_EX_data, 32'h8000_0000);
      check("idex_imm2", ID_EX_immediate_data, 32'h0000_07FF);

      // Reset mid-stream clears all three on the following edge
      A_data   = 32'hCAFE_F00D;
      B_data   = 32'h5555_AAAA;
      imm_data = 32'h0000_0004;
      reset = 1'b1;
      step();
      check("midrst_a",     A_ID_EX_data, 32'h0);
      check("midrst_b",     B_ID_EX_data, 32'h0);
      check("midrst_imm",   ID_EX_immediate_data, 32'h0);
      check("midrst_if_id", full_instruction, 32'h0000_0013);
      reset = 1'b0;
      step();
      check("post_rst_a", A_ID_EX_data, 32'hCAFE_F00D);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule : tb_id_stage_controller

// File: doc/id_stage_controller.md
Name: id_stage_controller

Overview:
- Decode-side pipeline block of the 5-stage RV32I-subset core.
- Registers the fetched instruction into the IF/ID latch.
- Decodes the latched instruction into one-hot operation controls.
- Registers operand A, operand B and the sign-extended immediate into the ID/EX latches for the execute stage.

Parameters:
- DATA_WIDTH, 32, width of instruction, operand and immediate paths.
- NOP_INSTR, 32'h0000_0013, bubble value (addi x0,x0,0) loaded into IF/ID on reset or flush.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- instruction_reg_out  in  32  instruction from the instruction register (IF stage).
- if_id_stall  in  1  holds the IF/ID latch when high.
- if_id_flush  in  1  loads NOP_INSTR into IF/ID when high (e.g. taken branch).
- full_instruction  out  32  registered IF/ID instruction.
- A_data  in  32  register-bank rs1 data (rs1 = full_instruction[19:15]).
- B_data  in  32  register-bank rs2 data (rs2 = full_instruction[24:20]).
- imm_data  in  32  sign-extended immediate for the current IF/ID instruction.
- A_ID_EX_data  out  32  registered rs1 data.
- B_ID_EX_data  out  32  registered rs2 data.
- ID_EX_immediate_data  out  32  registered immediate.
- add_control, sub_control, and_control, or_control  out  1 each  R-type ALU ops.
- addi_control, sll_control, sra_control  out  1 each  addi, shift-left-logical, shift-right-arithmetic.
- beq_control, sw_control, lw_control  out  1 each  branch-equal, store word, load word.
- illegal_instr  out  1  no supported encoding matched.

Behaviour:
- Clocking: single clock domain; all state updates on the rising edge of clock.
- Reset: synchronous, active-high.
- IF/ID update priority is reset > flush > stall > capture:
  - reset: full_instruction = NOP_INSTR.
  - else if_id_flush: full_instruction = NOP_INSTR.
  - else if_id_stall: full_instruction holds.
  - else: full_instruction = instruction_reg_out.
  - Flush and stall asserted together: flush wins.
- ID/EX latches (A, B, immediate):
  - reset: all three = 0.
  - otherwise: capture A_data, B_data, imm_data every cycle, with no enable.
  - Latency: input to output is 1 cycle.
- Decoder: purely combinational from full_instruction, so controls are valid in the same cycle as the IF/ID contents.
- Fields: opcode [6:0], funct3 [14:12], funct7 [31:25].
- Encodings:
  - add: 0110011 / 000 / 0000000
  - sub: 0110011 / 000 / 0100000
  - sll: 0110011 / 001 / 0000000
  - sra: 0110011 / 101 / 0100000
  - and: 0110011 / 111 / 0000000
  - or: 0110011 / 110 / 0000000
  - addi: 0010011 / 000 (funct7 ignored)
  - lw: 0000011 / 010
  - sw: 0100011 / 010
  - beq: 1100011 / 000
- Control outputs are one-hot or all-zero; never more than one is high.
- Any other encoding, including a non-matching funct7 on R-type: all controls 0, illegal_instr = 1.
- After reset, the NOP decodes as addi_control = 1, illegal_instr = 0.

Optional Feature:
- ID_EX_CTRL_EN defined:
  - The ten control outputs and illegal_instr become ID/EX-registered copies (1-cycle latency, aligned with A_ID_EX_data).
  - Their reset value is all 0.
- Not defined: the ten control outputs and illegal_instr stay combinational, as described above.

Decomposition:
- Shared package id_stage_pkg holds:
  - opcode constants: OP_RTYPE, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH.
  - funct3/funct7 constants.
  - NOP_INSTR.
  - a packed ctrl_t struct of the ten control bits.
- One natural sub-module, id_ex_reg32: 32-bit synchronous-reset pipeline register, instantiated three times (A, B, immediate).

Test Plan:
- Reset asserted 2 cycles → full_instruction = 0x00000013, addi_control = 1, all ID/EX outputs = 0.
- Capture 0x002081B3 (add x3,x1,x2), then next cycle 0x402081B3 → add_control, then sub_control, each high exactly one cycle after being driven; illegal_instr = 0.
- Sweep 0x00500093 (addi), 0x0080A283 (lw), 0x0050A623 (sw), 0x00208463 (beq), 0x4020D1B3 (sra) → only the matching single control high for each.
- Drive 0x0020C1B3 (xor, unsupported) → all controls 0, illegal_instr = 1.
- Hold 0x002081B3 with if_id_stall = 1 while input changes → full_instruction unchanged; assert stall and flush together → 0x00000013.
- A_data = 0xDEADBEEF, B_data = 0x12345678, imm_data = 0xFFFFFFF8 → the three ID/EX outputs match next edge; reset mid-stream → all three 0 on the following edge.
